// File: rtl/pipe_rate_ctrl.sv
// PIPE rate/width/PCLK change sequencer: drives Rate/Width/PCLKRate for a target
// generation, runs the PclkChangeOk/Ack handshake and collects per-lane PhyStatus.
module pipe_rate_ctrl #(
  parameter int LANESNUMBER    = 16,
  parameter int MAXGEN         = 5,
  parameter int GEN1_PIPEWIDTH = 8,
  parameter int GEN2_PIPEWIDTH = 8,
  parameter int GEN3_PIPEWIDTH = 8,
  parameter int GEN4_PIPEWIDTH = 8,
  parameter int GEN5_PIPEWIDTH = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic [2:0]             req_gen,
  input  logic [LANESNUMBER-1:0] lane_en,
  input  logic                   PclkChangeOk,
  input  logic [LANESNUMBER-1:0] PhyStatus,
  output logic [3:0]             Rate,
  output logic [1:0]             Width,
  output logic [4:0]             PCLKRate,
  output logic                   PclkChangeAck,
  output logic [2:0]             cur_gen,
  output logic                   busy,
  output logic                   done,
  output logic                   reject,
  output logic                   timeout_err,
  output logic [1:0]             state_dbg
);

  // Handshake: req_valid is a single-cycle strobe sampled only while busy is low;
  // there is no ready, a request seen while busy is dropped. done/reject/timeout_err
  // are one-cycle pulses. PclkChangeAck is held high from Ok until completion.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRIVE    = 2'd1,
    S_WAIT_OK  = 2'd2,
    S_WAIT_PHY = 2'd3
  } state_t;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] MAXGEN_L = 3'(MAXGEN);

  function automatic bit valid_w(input int w);
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  localparam bit WIDTHS_OK = valid_w(GEN1_PIPEWIDTH) && valid_w(GEN2_PIPEWIDTH) &&
                             valid_w(GEN3_PIPEWIDTH) && valid_w(GEN4_PIPEWIDTH) &&
                             valid_w(GEN5_PIPEWIDTH);

  if (!WIDTHS_OK) begin : g_bad_width
    $error("pipe_rate_ctrl: every GENg_PIPEWIDTH must be 8, 16 or 32");
  end
  if (MAXGEN < 1 || MAXGEN > 5) begin : g_bad_maxgen
    $error("pipe_rate_ctrl: MAXGEN must be in 1..5");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("pipe_rate_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  function automatic logic [1:0] enc_w(input int w);
    return (w == 32) ? 2'd2 : (w == 16) ? 2'd1 : 2'd0;
  endfunction

  function automatic logic [1:0] width_of(input logic [2:0] g);
    logic [1:0] r;
    case (g)
      3'd2:    r = enc_w(GEN2_PIPEWIDTH);
      3'd3:    r = enc_w(GEN3_PIPEWIDTH);
      3'd4:    r = enc_w(GEN4_PIPEWIDTH);
      3'd5:    r = enc_w(GEN5_PIPEWIDTH);
      default: r = enc_w(GEN1_PIPEWIDTH);
    endcase
    return r;
  endfunction

  // Wider data path at the same line rate means a proportionally slower PCLK.
  function automatic logic [4:0] pclk_of(input logic [2:0] g);
    return {2'b00, g} + 5'd1 - {3'b000, width_of(g)};
  endfunction

  function automatic logic [3:0] rate_of(input logic [2:0] g);
    return {1'b0, g - 3'd1};
  endfunction

  state_t                 state_q, state_d;
  logic [2:0]             tgt_q, tgt_d;
  logic [3:0]             rate_q, rate_d, sv_rate_q, sv_rate_d;
  logic [1:0]             width_q, width_d, sv_width_q, sv_width_d;
  logic [4:0]             pclk_q, pclk_d, sv_pclk_q, sv_pclk_d;
  logic                   ack_q, ack_d;
  logic [2:0]             cur_gen_q, cur_gen_d;
  logic                   done_q, done_d;
  logic                   reject_q, reject_d;
  logic                   tout_q, tout_d;
  logic [LANESNUMBER-1:0] ps_seen_q, ps_seen_d, ps_all;
  logic [CW-1:0]          cnt_q, cnt_d;

  // Current-cycle PhyStatus counts toward completion, not just the sticky bits.
  assign ps_all = ps_seen_q | PhyStatus;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    rate_d     = rate_q;
    width_d    = width_q;
    pclk_d     = pclk_q;
    sv_rate_d  = sv_rate_q;
    sv_width_d = sv_width_q;
    sv_pclk_d  = sv_pclk_q;
    ack_d      = ack_q;
    cur_gen_d  = cur_gen_q;
    done_d     = 1'b0;
    reject_d   = 1'b0;
    tout_d     = 1'b0;
    ps_seen_d  = ps_seen_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_gen == 3'd0 || req_gen > MAXGEN_L) begin
            reject_d = 1'b1;
          end else if (req_gen == cur_gen_q) begin
            done_d = 1'b1;
          end else begin
            tgt_d      = req_gen;
            sv_rate_d  = rate_q;
            sv_width_d = width_q;
            sv_pclk_d  = pclk_q;
            state_d    = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        rate_d    = rate_of(tgt_q);
        width_d   = width_of(tgt_q);
        pclk_d    = pclk_of(tgt_q);
        ps_seen_d = '0;
        cnt_d     = '0;
        state_d   = S_WAIT_OK;
      end
      S_WAIT_OK: begin
        ps_seen_d = ps_all;
        if (PclkChangeOk) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_WAIT_PHY;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          rate_d  = sv_rate_q;
          width_d = sv_width_q;
          pclk_d  = sv_pclk_q;
          ack_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_PHY: begin
        ps_seen_d = ps_all;
        if (&(ps_all | ~lane_en)) begin
          ack_d     = 1'b0;
          cur_gen_d = tgt_q;
          done_d    = 1'b1;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tout_d  = 1'b1;
          rate_d  = sv_rate_q;
          width_d = sv_width_q;
          pclk_d  = sv_pclk_q;
          ack_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= 3'd1;
      rate_q     <= 4'd0;
      width_q    <= width_of(3'd1);
      pclk_q     <= pclk_of(3'd1);
      sv_rate_q  <= 4'd0;
      sv_width_q <= width_of(3'd1);
      sv_pclk_q  <= pclk_of(3'd1);
      ack_q      <= 1'b0;
      cur_gen_q  <= 3'd1;
      done_q     <= 1'b0;
      reject_q   <= 1'b0;
      tout_q     <= 1'b0;
      ps_seen_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      rate_q     <= rate_d;
      width_q    <= width_d;
      pclk_q     <= pclk_d;
      sv_rate_q  <= sv_rate_d;
      sv_width_q <= sv_width_d;
      sv_pclk_q  <= sv_pclk_d;
      ack_q      <= ack_d;
      cur_gen_q  <= cur_gen_d;
      done_q     <= done_d;
      reject_q   <= reject_d;
      tout_q     <= tout_d;
      ps_seen_q  <= ps_seen_d;
      cnt_q      <= cnt_d;
    end
  end

  assign Rate          = rate_q;
  assign Width         = width_q;
  assign PCLKRate      = pclk_q;
  assign PclkChangeAck = ack_q;
  assign cur_gen       = cur_gen_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign reject        = reject_q;
  assign timeout_err   = tout_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_pipe_rate_ctrl.sv
// Directed bench for pipe_rate_ctrl: Gen4 at 32b, all others 8b, 16-cycle timeout.
module tb_pipe_rate_ctrl;

  localparam int LN = 16;

  logic          CLK = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic [2:0]    req_gen = 3'd0;
  logic [LN-1:0] lane_en = '1;
  logic          PclkChangeOk = 1'b0;
  logic [LN-1:0] PhyStatus = '0;
  logic [3:0]    Rate;
  logic [1:0]    Width;
  logic [4:0]    PCLKRate;
  logic          PclkChangeAck;
  logic [2:0]    cur_gen;
  logic          busy, done, reject, timeout_err;
  logic [1:0]    state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [10:0] exp_q[$];

  pipe_rate_ctrl #(
    .LANESNUMBER(LN), .MAXGEN(5),
    .GEN1_PIPEWIDTH(8), .GEN2_PIPEWIDTH(8), .GEN3_PIPEWIDTH(8),
    .GEN4_PIPEWIDTH(32), .GEN5_PIPEWIDTH(8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_gen(req_gen),
    .lane_en(lane_en), .PclkChangeOk(PclkChangeOk), .PhyStatus(PhyStatus),
    .Rate(Rate), .Width(Width), .PCLKRate(PCLKRate), .PclkChangeAck(PclkChangeAck),
    .cur_gen(cur_gen), .busy(busy), .done(done), .reject(reject),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: expected {Rate, Width, PCLKRate} words, popped by check_pins
  task automatic check_pins(input string tag);
    logic [10:0] e;
    e = exp_q.pop_front();
    check(tag, {Rate, Width, PCLKRate}, e);
  endtask

  // driver: one-cycle request strobe, sampled at the next edge (E0)
  task automatic send_req(input logic [2:0] g);
    req_valid = 1'b1;
    req_gen   = g;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    exp_q.push_back({4'd0, 2'd0, 5'd2});
    check_pins({tag, "_pins"});
    check({tag, "_cur_gen"}, cur_gen, 3'd1);
    check({tag, "_ack"}, PclkChangeAck, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_reject"}, reject, 1'b0);
    check({tag, "_tout"}, timeout_err, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();

    // timeout in WAIT_OK: Gen1 -> Gen2, Ok never arrives
    send_req(3'd2);
    check("to_busy", busy, 1'b1);
    tick();
    exp_q.push_back({4'd1, 2'd0, 5'd3});
    check_pins("to_gen2_pins");
    for (int i = 0; i < 15; i++) tick();
    check("to_not_yet", timeout_err, 1'b0);
    check("to_busy_hold", busy, 1'b1);
    tick();
    check("to_pulse", timeout_err, 1'b1);
    exp_q.push_back({4'd0, 2'd0, 5'd2});
    check_pins("to_revert_pins");
    check("to_cur_gen", cur_gen, 3'd1);
    check("to_busy_low", busy, 1'b0);
    check("to_ack", PclkChangeAck, 1'b0);
    tick();
    check("to_pulse_end", timeout_err, 1'b0);

    // Gen1 -> Gen3, all lanes, Ok at E3, PhyStatus at E5
    send_req(3'd3);
    check("g3_busy", busy, 1'b1);
    tick();
    exp_q.push_back({4'd2, 2'd0, 5'd4});
    check_pins("g3_pins");
    tick();
    check("g3_ack_wait", PclkChangeAck, 1'b0);
    PclkChangeOk = 1'b1;
    tick();
    PclkChangeOk = 1'b0;
    check("g3_ack", PclkChangeAck, 1'b1);
    tick();
    check("g3_no_done", done, 1'b0);
    PhyStatus = '1;
    tick();
    PhyStatus = '0;
    check("g3_done", done, 1'b1);
    check("g3_cur_gen", cur_gen, 3'd3);
    check("g3_ack_drop", PclkChangeAck, 1'b0);
    check("g3_busy_low", busy, 1'b0);
    tick();
    check("g3_done_end", done, 1'b0);

    // Gen3 -> Gen4 at 32b, lanes 0..7 enabled, staggered PhyStatus
    lane_en = 16'h00FF;
    send_req(3'd4);
    tick();
    exp_q.push_back({4'd3, 2'd2, 5'd3});
    check_pins("g4_pins");
    PclkChangeOk = 1'b1;
    PhyStatus    = 16'h0001;
    tick();
    PclkChangeOk = 1'b0;
    PhyStatus    = '0;
    check("g4_ack", PclkChangeAck, 1'b1);
    for (int i = 1; i < 8; i++) begin
      PhyStatus = LN'(1) << i;
      if (i == 3) PhyStatus[9] = 1'b1;
      tick();
      PhyStatus = '0;
      if (i < 7) begin
        check($sformatf("g4_lane%0d_pending", i), done, 1'b0);
        if (i == 4) begin
          tick();
          check("g4_gap_busy", busy, 1'b1);
        end
      end
    end
    check("g4_done", done, 1'b1);
    check("g4_cur_gen", cur_gen, 3'd4);
    tick();

    // same-gen request and invalid requests
    send_req(3'd4);
    check("same_done", done, 1'b1);
    check("same_busy", busy, 1'b0);
    exp_q.push_back({4'd3, 2'd2, 5'd3});
    check_pins("same_pins");
    tick();
    check("same_done_end", done, 1'b0);
    foreach (exp_q[i]) check("sb_leftover", 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      logic [2:0] bad;
      bad = (k == 0) ? 3'd0 : (k == 1) ? 3'd6 : 3'd7;
      send_req(bad);
      check($sformatf("inv%0d_reject", bad), reject, 1'b1);
      check($sformatf("inv%0d_busy", bad), busy, 1'b0);
      check($sformatf("inv%0d_done", bad), done, 1'b0);
      tick();
      check($sformatf("inv%0d_reject_end", bad), reject, 1'b0);
    end
    check("inv_cur_gen", cur_gen, 3'd4);

    // Gen4 -> Gen2, request while busy ignored, reset in WAIT_PHY
    lane_en = '1;
    send_req(3'd2);
    tick();
    exp_q.push_back({4'd1, 2'd0, 5'd3});
    check_pins("g2_pins");
    PclkChangeOk = 1'b1;
    tick();
    PclkChangeOk = 1'b0;
    PhyStatus    = 16'h000F;
    tick();
    PhyStatus = '0;
    send_req(3'd5);
    check("busy_req_busy", busy, 1'b1);
    check("busy_req_state", state_dbg, 2'd3);
    check("busy_req_done", done, 1'b0);
    check("busy_req_reject", reject, 1'b0);
    exp_q.push_back({4'd1, 2'd0, 5'd3});
    check_pins("busy_req_pins");
    reset = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    tick();
    check("mid_rst_done", done, 1'b0);
    reset = 1'b0;
    tick();
    check("post_rst_done", done, 1'b0);

    // Gen1 -> Gen5 after reset
    send_req(3'd5);
    tick();
    exp_q.push_back({4'd4, 2'd0, 5'd6});
    check_pins("g5_pins");
    PclkChangeOk = 1'b1;
    tick();
    PclkChangeOk = 1'b0;
    PhyStatus    = '1;
    tick();
    PhyStatus = '0;
    check("g5_done", done, 1'b1);
    check("g5_cur_gen", cur_gen, 3'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_rate_ctrl.md
# pipe_rate_ctrl

Parametrised PIPE rate/width/PCLK change sequencer for the PCIe physical layer. On a speed-change request from the LTSSM it:
- drives the PIPE `Rate`, `Width` and `PCLKRate` pins for the target generation (Gen1–Gen5), each with its own PIPE width;
- runs the `PclkChangeOk`/`PclkChangeAck` handshake;
- waits for `PhyStatus` from every enabled lane.

It sits between the LTSSM and the PIPE command/status pins. It adds per-lane completion tracking, lane masking, a timeout with rollback, and request rejection.

## Interface
- `LANESNUMBER`, 16, number of PIPE lanes tracked
- `MAXGEN`, 5, highest supported generation (1..5)
- `GEN1_PIPEWIDTH` … `GEN5_PIPEWIDTH`, 8 each, PIPE data width per generation (8, 16 or 32)
- `TIMEOUT_CYCLES`, 4096, maximum cycles allowed in any wait state

- `CLK`  in  1  block clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  speed-change request strobe
- `req_gen`  in  3  target generation, 1..5
- `lane_en`  in  LANESNUMBER  lanes whose `PhyStatus` is required
- `PclkChangeOk`  in  1  PHY ready for the PCLK change
- `PhyStatus`  in  LANESNUMBER  per-lane PHY completion pulse
- `Rate`  out  4  PIPE rate, equal to gen−1
- `Width`  out  2  PIPE width: 0 = 8b, 1 = 16b, 2 = 32b
- `PCLKRate`  out  5  PCLK code: 0 = 62.5M, 1 = 125M, 2 = 250M, 3 = 500M, 4 = 1G, 5 = 2G, 6 = 4G
- `PclkChangeAck`  out  1  MAC acknowledge of the PCLK change
- `cur_gen`  out  3  currently committed generation
- `busy`  out  1  change in progress; requests are ignored while high
- `done`  out  1  one-cycle completion pulse
- `reject`  out  1  one-cycle pulse for an invalid request
- `timeout_err`  out  1  one-cycle pulse when a wait state times out

## Operation

**Encoding.** For generation g:
- `Rate` = g−1.
- `Width` = log2(GENg_PIPEWIDTH/8).
- `PCLKRate` = (g+1) − `Width`. Gen1 at 8b gives code 2 (250 MHz); Gen5 at 32b gives code 4 (1 GHz).
- Width and code tables are elaborated from the parameters. Any GENg_PIPEWIDTH other than 8, 16 or 32 is an elaboration error.

**State machine:** IDLE, DRIVE, WAIT_OK, WAIT_PHY.

IDLE (`busy` = 0), when `req_valid` = 1:
- `req_gen` = 0 or `req_gen` > MAXGEN → `reject` pulse; stay in IDLE.
- `req_gen` == `cur_gen` → `done` pulse; no pin changes; stay in IDLE.
- Otherwise → latch the target and save the current Rate/Width/PCLKRate; go to DRIVE.

DRIVE:
- Load the target Rate/Width/PCLKRate onto the pins.
- Clear the per-lane sticky bits `ps_seen`.
- Go to WAIT_OK.

WAIT_OK:
- When `PclkChangeOk` = 1 → `PclkChangeAck` ← 1; go to WAIT_PHY.

WAIT_PHY:
- When `&(ps_seen | ~lane_en)` = 1 → `PclkChangeAck` ← 0, `cur_gen` ← target, `done` pulse; go to IDLE.

**PhyStatus capture.**
- `ps_seen[i]` sets when `PhyStatus[i]` = 1 in WAIT_OK or WAIT_PHY.
- The completion check includes the current-cycle `PhyStatus` OR'd into `ps_seen`.
- `lane_en` = 0 makes completion immediate on the first WAIT_PHY cycle.

**Timeout.**
- The counter clears on entry to WAIT_OK or WAIT_PHY.
- If `TIMEOUT_CYCLES` cycles elapse in that state without its exit condition:
  - `timeout_err` pulses;
  - the saved Rate/Width/PCLKRate are restored and `PclkChangeAck` ← 0;
  - `cur_gen` is unchanged;
  - the FSM goes to IDLE.
- Simultaneous exit condition and expiry: the exit condition wins.

`req_valid` is ignored while `busy` = 1.

## Timing

**Reset values** (asynchronous):
- State IDLE.
- `Rate` = 0, `Width` = enc(GEN1), `PCLKRate` = code(GEN1).
- `cur_gen` = 1.
- `PclkChangeAck` = `busy` = `done` = `reject` = `timeout_err` = 0.
- `ps_seen` = 0, counter = 0.

Reset asserted mid-change aborts the change immediately, with no `done` or `timeout_err` pulse.

**Cycle sequence** (all outputs registered):
- Request accepted at edge E0 → `busy` = 1 after E0.
- New Rate/Width/PCLKRate visible after E1.
- `PclkChangeOk` sampled high at edge Ek → `PclkChangeAck` = 1 after Ek. The earliest Ek is E2.
- Last lane's `PhyStatus` sampled at edge Em → after Em: `PclkChangeAck` = 0, `done` = 1, `busy` = 0, `cur_gen` = target.
- `done` drops after Em+1.
- A new request is accepted at Em+1.

**Single-cycle requests.**
- Same-gen request at E0 → `done` = 1 after E0.
- Invalid request at E0 → `reject` = 1 after E0.
- In both cases `busy` stays 0.

`PhyStatus` pulses arriving in WAIT_OK, before the Ack, still count.

## Test plan
- Reset, then req_gen = 3 with all Gen widths = 8 → Rate = 2, Width = 0, PCLKRate = 4 after E1. Ok at E3 → Ack after E3. PhyStatus on all 16 lanes at E5 → done after E5, cur_gen = 3, Ack = 0.
- Staggered PhyStatus with GEN4_PIPEWIDTH = 32, req_gen = 4, lane_en = 0x00FF: lanes 0..7 pulse on different cycles, lanes 8..15 never pulse → done one edge after lane 7's pulse. Also check PCLKRate = 3.
- Timeout with TIMEOUT_CYCLES = 16: PclkChangeOk never asserts → timeout_err after 16 WAIT_OK cycles; pins revert to Gen1 values (Rate 0, Width 0, PCLKRate 2); cur_gen = 1.
- Invalid requests: req_gen = 0, 6 and 7 → reject pulse each time, busy stays 0. req_gen = cur_gen → done pulse with no pin change.
- Request while busy, then reset: req_gen = 5 issued in WAIT_PHY is ignored. Reset asserted in WAIT_PHY → all outputs return to reset values immediately, with no done pulse.
